// File: rtl/arrow_queue_if.sv
// Handshake bundle between the arrow-button conditioner and its user (game core / board pins).
// The master drives raw buttons and step/clear; the slave (arrow_queue) returns direction state.
interface arrow_queue_if;
    logic       arrow_up;
    logic       arrow_down;
    logic       arrow_left;
    logic       arrow_right;
    logic       step;
    logic       clear;
    logic [1:0] dir;
    logic [2:0] pending;
    logic       press_pulse;
    logic [7:0] drop_count;

    modport master (
        output arrow_up, arrow_down, arrow_left, arrow_right, step, clear,
        input  dir, pending, press_pulse, drop_count
    );

    modport slave (
        input  arrow_up, arrow_down, arrow_left, arrow_right, step, clear,
        output dir, pending, press_pulse, drop_count
    );
endinterface

// File: rtl/arrow_queue.sv
// Arrow-button conditioner: sync, debounce, press detection and a small turn queue feeding the snake core.
// Optional dropped-press counter is built only when ARROW_DROP_COUNT_EN is defined.
module arrow_queue #(
    parameter int         DEBOUNCE_CYCLES = 100000,
    parameter int         QUEUE_DEPTH     = 2,
    parameter logic [3:0] ACTIVE_LOW_MASK = 4'b0011,
    parameter logic [1:0] INIT_DIR        = 2'd1
) (
    input  logic          clk,
    input  logic          reset,
    arrow_queue_if.slave  bus
);

    localparam int         CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] LAST_PTR = 2'(QUEUE_DEPTH - 1);
    localparam logic [2:0] DEPTH    = 3'(QUEUE_DEPTH);

    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    level;
    logic [3:0]    stable_q, stable_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    rise;
    logic          anyPress;
    logic [1:0]    reqDir;

    logic [1:0]    mem_q [4];
    logic [1:0]    mem_d [4];
    logic [1:0]    rdPtr_q, rdPtr_d;
    logic [1:0]    wrPtr_q, wrPtr_d;
    logic [2:0]    count_q, count_d;
    logic [1:0]    dir_q, dir_d;
    logic          pressPulse_q;

    logic          popEn;
    logic [2:0]    countPop;
    logic [1:0]    dirPop;
    logic [1:0]    tailPtr;
    logic [1:0]    refDir;
    logic          pushValid;

    function automatic logic [1:0] nextPtr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    assign raw   = {bus.arrow_right, bus.arrow_left, bus.arrow_down, bus.arrow_up};
    assign level = sync2_q ^ ACTIVE_LOW_MASK;

    // Synchronizers reset to the released pin level so no phantom press appears after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= ACTIVE_LOW_MASK;
            sync2_q <= ACTIVE_LOW_MASK;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        rise     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (level[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = level[i];
                    rise[i]     = level[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= 4'b0000;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Simultaneous presses collapse to one request: up > down > left > right.
    always_comb begin
        anyPress = |rise;
        reqDir   = 2'd3;
        if (rise[0])      reqDir = 2'd0;
        else if (rise[1]) reqDir = 2'd1;
        else if (rise[2]) reqDir = 2'd2;
    end

    assign popEn    = bus.step && (count_q != 3'd0);
    assign countPop = popEn ? count_q - 3'd1 : count_q;
    assign dirPop   = popEn ? mem_q[rdPtr_q] : dir_q;
    assign tailPtr  = (wrPtr_q == 2'd0) ? LAST_PTR : wrPtr_q - 2'd1;
    assign refDir   = (countPop != 3'd0) ? mem_q[tailPtr] : dirPop;
    assign pushValid = anyPress && (reqDir != refDir) && (reqDir != (refDir ^ 2'd1));

    // Pop is evaluated before the push so a press on a step cycle sees the post-pop reference.
    always_comb begin
        mem_d   = mem_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        dir_d   = dir_q;
        if (bus.clear) begin
            rdPtr_d = 2'd0;
            wrPtr_d = 2'd0;
            count_d = 3'd0;
            dir_d   = INIT_DIR;
        end else begin
            dir_d   = dirPop;
            count_d = countPop;
            if (popEn) rdPtr_d = nextPtr(rdPtr_q);
            if (pushValid && (countPop != DEPTH)) begin
                mem_d[wrPtr_q] = reqDir;
                wrPtr_d        = nextPtr(wrPtr_q);
                count_d        = countPop + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 2'd0;
            rdPtr_q      <= 2'd0;
            wrPtr_q      <= 2'd0;
            count_q      <= 3'd0;
            dir_q        <= INIT_DIR;
            pressPulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
            dir_q        <= dir_d;
            pressPulse_q <= anyPress;
        end
    end

    assign bus.dir         = dir_q;
    assign bus.pending     = count_q;
    assign bus.press_pulse = pressPulse_q;

`ifdef ARROW_DROP_COUNT_EN
    logic       dropEvent;
    logic [7:0] dropCount_q;

    assign dropEvent = !bus.clear && pushValid && (countPop == DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropCount_q <= 8'd0;
        end else if (bus.clear) begin
            dropCount_q <= 8'd0;
        end else if (dropEvent && (dropCount_q != 8'hFF)) begin
            dropCount_q <= dropCount_q + 8'd1;
        end
    end

    assign bus.drop_count = dropCount_q;
`else
    assign bus.drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_arrow_queue.sv
// Directed self-checking bench for arrow_queue with DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, default mask.
// Inputs change and outputs are sampled on the falling clock edge, away from the active edge.
module tb_arrow_queue;

    localparam logic [3:0] MASK = 4'b0011;
    localparam int BTN_UP = 0, BTN_DOWN = 1, BTN_LEFT = 2, BTN_RIGHT = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [7:0] expDropFull;

    arrow_queue_if bus ();

    arrow_queue #(
        .DEBOUNCE_CYCLES (4),
        .QUEUE_DEPTH     (2),
        .ACTIVE_LOW_MASK (MASK),
        .INIT_DIR        (2'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch reports tag, observed and expected.
    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // Compares the three main outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [1:0] expDir,
                               input logic [2:0] expPending, input logic expPulse);
        checkVal({tag, ".dir"}, {6'd0, bus.dir}, {6'd0, expDir});
        checkVal({tag, ".pending"}, {5'd0, bus.pending}, {5'd0, expPending});
        checkVal({tag, ".press_pulse"}, {7'd0, bus.press_pulse}, {7'd0, expPulse});
    endtask

    // Drives a button to its pressed or released pin level, honouring polarity.
    task automatic setButton(input int b, input logic pressed);
        logic lvl;
        lvl = MASK[b] ? ~pressed : pressed;
        case (b)
            BTN_UP:   bus.arrow_up    = lvl;
            BTN_DOWN: bus.arrow_down  = lvl;
            BTN_LEFT: bus.arrow_left  = lvl;
            default:  bus.arrow_right = lvl;
        endcase
    endtask

    // Full press-and-release: pulse must appear exactly 6 cycles after the edge, then never again.
    task automatic applyStimulus(input int b, input string tag);
        setButton(b, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkVal({tag, ".pulse_timing"}, {7'd0, bus.press_pulse}, (k == 6) ? 8'd1 : 8'd0);
        end
        setButton(b, 1'b0);
        repeat (8) begin
            @(negedge clk);
            checkVal({tag, ".no_release_pulse"}, {7'd0, bus.press_pulse}, 8'd0);
        end
    endtask

    task automatic pulseStep();
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic pulseClear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    // Linear directed sequence covering every scenario of the plan.
    initial begin
        total = 0;
        bad   = 0;
`ifdef ARROW_DROP_COUNT_EN
        expDropFull = 8'd1;
`else
        expDropFull = 8'd0;
`endif
        reset     = 1'b0;
        bus.step  = 1'b0;
        bus.clear = 1'b0;
        for (int b = 0; b < 4; b++) setButton(b, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("reset_state", 2'd1, 3'd0, 1'b0);
        checkVal("reset_state.drop_count", bus.drop_count, 8'd0);
        reset = 1'b1;
        repeat (100) begin
            @(negedge clk);
            checkOutput("idle", 2'd1, 3'd0, 1'b0);
        end

        $display("[TB] short glitch on right");
        setButton(BTN_RIGHT, 1'b1);
        repeat (3) @(negedge clk);
        setButton(BTN_RIGHT, 1'b0);
        repeat (8) begin
            @(negedge clk);
            checkOutput("glitch", 2'd1, 3'd0, 1'b0);
        end

        $display("[TB] held right, single event");
        setButton(BTN_RIGHT, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checkVal("hold.pulse", {7'd0, bus.press_pulse}, (k == 6) ? 8'd1 : 8'd0);
            if (k == 6) checkVal("hold.pending", {5'd0, bus.pending}, 8'd1);
        end
        setButton(BTN_RIGHT, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("hold.after", 2'd1, 3'd1, 1'b0);
        pulseStep();
        checkOutput("step_right", 2'd3, 3'd0, 1'b0);

        pulseClear();
        checkOutput("clear_to_init", 2'd1, 3'd0, 1'b0);

        $display("[TB] reversal rejection");
        applyStimulus(BTN_UP, "up_reverse");
        checkOutput("up_reverse.state", 2'd1, 3'd0, 1'b0);

        applyStimulus(BTN_LEFT, "left");
        checkOutput("left.state", 2'd1, 3'd1, 1'b0);
        applyStimulus(BTN_RIGHT, "right_vs_tail");
        checkOutput("right_vs_tail.state", 2'd1, 3'd1, 1'b0);
        pulseClear();
        checkOutput("clear2", 2'd1, 3'd0, 1'b0);

        $display("[TB] fill queue and drop");
        applyStimulus(BTN_LEFT, "fill_left");
        applyStimulus(BTN_UP, "fill_up");
        checkOutput("fill.state", 2'd1, 3'd2, 1'b0);
        applyStimulus(BTN_RIGHT, "fill_right");
        checkOutput("full.state", 2'd1, 3'd2, 1'b0);
        checkVal("full.drop_count", bus.drop_count, expDropFull);
        pulseStep();
        checkOutput("pop1", 2'd2, 3'd1, 1'b0);
        pulseStep();
        checkOutput("pop2", 2'd0, 3'd0, 1'b0);
        pulseStep();
        checkOutput("pop_empty", 2'd0, 3'd0, 1'b0);

        $display("[TB] clear beats step and press");
        applyStimulus(BTN_LEFT, "queue_left");
        checkOutput("queue_left.state", 2'd0, 3'd1, 1'b0);
        setButton(BTN_DOWN, 1'b1);
        repeat (5) @(negedge clk);
        bus.step  = 1'b1;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.step  = 1'b0;
        bus.clear = 1'b0;
        checkOutput("clear_prio", 2'd1, 3'd0, 1'b1);
        checkVal("clear_prio.drop_count", bus.drop_count, 8'd0);
        setButton(BTN_DOWN, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("clear_prio.after", 2'd1, 3'd0, 1'b0);

        $display("[TB] reset mid-debounce");
        applyStimulus(BTN_RIGHT, "pre_reset_right");
        setButton(BTN_LEFT, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("pre_reset", 2'd1, 3'd1, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 2'd1, 3'd0, 1'b0);
        checkVal("async_reset.drop_count", bus.drop_count, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkVal("post_reset.pulse", {7'd0, bus.press_pulse}, (k == 6) ? 8'd1 : 8'd0);
        end
        checkOutput("post_reset.state", 2'd1, 3'd1, 1'b1);
        setButton(BTN_LEFT, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("final", 2'd1, 3'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arrow_queue.md
Name: arrow_queue

Overview:
- Input-conditioning stage directly upstream of the snake game core.
- Synchronizes and debounces the four arrow buttons, then turns presses into direction commands.
- Rejects reversals and duplicates, and buffers up to QUEUE_DEPTH pending turns.
- The game core pulses step once per move tick and reads dir, so fast double turns survive between ticks.
- Direction encoding: 0 up, 1 down, 2 left, 3 right.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable clk cycles needed to accept a level change (10 ms at 10 MHz).
- QUEUE_DEPTH, 2: pending-turn FIFO depth; legal values 1 to 4.
- ACTIVE_LOW_MASK, 4'b0011: per-button polarity, bit set means active-low. Bit order: 0 up, 1 down, 2 left, 3 right.
- INIT_DIR, 2'd1: direction after reset or clear.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- arrow_up  input  1  raw button, asynchronous, polarity per ACTIVE_LOW_MASK[0]
- arrow_down  input  1  raw button, polarity per ACTIVE_LOW_MASK[1]
- arrow_left  input  1  raw button, polarity per ACTIVE_LOW_MASK[2]
- arrow_right  input  1  raw button, polarity per ACTIVE_LOW_MASK[3]
- step  input  1  one-cycle pulse from game tick; consume one queued turn
- clear  input  1  synchronous flush: queue emptied, dir set to INIT_DIR
- dir  output  2  direction to apply on the current move
- pending  output  3  number of queued turns (0 to QUEUE_DEPTH)
- press_pulse  output  1  one-cycle pulse on every debounced press, accepted or not; used for seed mixing
- drop_count  output  8  dropped-press counter (optional feature)

Behaviour:
- Reset (asynchronous, reset=0) clears everything:
  - dir=INIT_DIR, pending=0, press_pulse=0, drop_count=0.
  - All debounce counters 0; all stable states released.
  - Synchronizer flops loaded with the released level.
- Synchronizer: 2 flops per button. Polarity is normalized after sync, so internally 1 = pressed.
- Debounce, per button:
  - Counter increments while the synced level differs from the stable level.
  - Counter returns to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, the stable level flips and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Press event: stable level goes released to pressed. No event on release.
  - Latency from raw edge to press event is 2 + DEBOUNCE_CYCLES clk.
- Multiple press events in one cycle:
  - Only the highest priority is taken: up > down > left > right.
  - The others are discarded without counting as drops.
  - press_pulse fires once.
- Reference direction for a push:
  - The queue tail entry if the queue is non-empty after any same-cycle pop.
  - Otherwise dir after any same-cycle pop.
- A push is rejected when the requested direction equals the reference or is its opposite (0/1 or 2/3).
  - A rejected push is not a drop.
- A push is dropped when it is valid but the queue holds QUEUE_DEPTH entries after any same-cycle pop.
- step handling:
  - step with pending>0: the head pops into dir on the next clk edge and pending decrements.
  - step with pending=0: dir holds.
- step and press in the same cycle: pop first, then evaluate the push against the post-pop reference.
  - Net effect on a full queue: one out, one in, pending unchanged.
- clear has priority over step and press in the same cycle.
  - The press is discarded; press_pulse still fires.
  - Debounce state is untouched by clear.
- FIFO: circular read/write pointers mod QUEUE_DEPTH, with a separate count.
  - Pointer wrap must not corrupt entries at QUEUE_DEPTH=3.
- All outputs are registered. press_pulse is high exactly one cycle per event.
- A button held indefinitely generates exactly one event.

Optional Feature:
- Macro: ARROW_DROP_COUNT_EN.
- Defined: drop_count increments on each dropped push (queue full), saturates at 255, and is cleared only by reset or clear.
- Undefined: drop_count is tied to 8'd0 and no counter logic is generated.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, default mask):
- Release reset, no buttons pressed -> dir=1, pending=0, press_pulse=0 for 100 cycles.
- Drive arrow_right=1 for 3 cycles, then 0 -> no event, pending stays 0.
- Hold arrow_right=1 for 10 cycles -> exactly one press_pulse, 6 cycles after the edge; pending=1.
  - Then pulse step -> dir=3 on the next cycle, pending=0.
- From dir=1 (down), press up (arrow_up=0) -> press_pulse, rejected, pending=0.
- From dir=1, press left, then right -> right is rejected as opposite of tail 2; pending=1.
- From dir=1, press left, up, right, with each event completing before the next press:
  - Right is dropped as full; with the macro, drop_count=1.
  - Then step -> dir=2, pending=1; step -> dir=0, pending=0.
- With pending=1 (left queued), assert clear on the same cycle as step and a press -> dir=1, pending=0, press_pulse=1.
- Assert reset mid-debounce (counter=2) -> all outputs return to reset values immediately.
  - After release, a full press is still required to produce an event.
